// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : Load/store unit between the pipeline MEM stage and a simple
//               request/acknowledge data bus. Checks each access for a legal
//               size code and natural alignment, formats store strobes/data
//               onto byte lanes, waits for the bus acknowledge and returns
//               sign- or zero-extended load data for one writeback cycle.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               m_mem_read/m_mem_write   - load / store request
//               m_mem_mode               - funct3 size/sign code
//               ex_result, rs2_data      - byte address (or ALU result), store data
//               rd_index, wb_reg_write, wb_memtoreg - writeback controls in
//               dmem_*                   - data bus request/response
//               mem_stall, misalign      - pipeline freeze, access fault
//               wb_result_out, rd_index_out, wb_reg_write_out, wb_memtoreg_out
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m_mem_read,
    input  logic                   m_mem_write,
    input  logic [2:0]             m_mem_mode,
    input  logic [XLEN-1:0]        ex_result,
    input  logic [XLEN-1:0]        rs2_data,
    input  logic [RFIDX_WIDTH-1:0] rd_index,
    input  logic                   wb_reg_write,
    input  logic                   wb_memtoreg,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [XLEN-1:0]        dmem_addr,
    output logic [XLEN-1:0]        dmem_wdata,
    output logic [3:0]             dmem_wstrb,
    input  logic                   dmem_ack,
    input  logic [XLEN-1:0]        dmem_rdata,
    output logic                   mem_stall,
    output logic                   misalign,
    output logic [XLEN-1:0]        wb_result_out,
    output logic [RFIDX_WIDTH-1:0] rd_index_out,
    output logic                   wb_reg_write_out,
    output logic                   wb_memtoreg_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_dmem_req;
    logic             r_dmem_we;
    logic [XLEN-1:0]  r_dmem_addr;
    logic [XLEN-1:0]  r_dmem_wdata;
    logic [3:0]       r_dmem_wstrb;
    logic [2:0]       r_mode;
    logic [1:0]       r_off;
    logic [XLEN-1:0]  r_load_data;

    logic             w_is_load;
    logic             w_is_store;
    logic             w_mode_legal;
    logic             w_aligned;
    logic             w_valid;
    logic             w_idle;
    logic             w_accept;
    logic [3:0]       w_st_wstrb;
    logic [XLEN-1:0]  w_st_wdata;
    logic [7:0]       w_ld_byte;
    logic [15:0]      w_ld_half;
    logic [XLEN-1:0]  w_ld_fmt;

    // Exactly one of read/write must be set; both set is treated as a fault.
    assign w_is_load  = m_mem_read & ~m_mem_write;
    assign w_is_store = m_mem_write & ~m_mem_read;

    always_comb begin
        w_mode_legal = 1'b0;
        if (w_is_load) begin
            w_mode_legal = (m_mem_mode == 3'b000) || (m_mem_mode == 3'b001) ||
                           (m_mem_mode == 3'b010) || (m_mem_mode == 3'b100) ||
                           (m_mem_mode == 3'b101);
        end else if (w_is_store) begin
            w_mode_legal = (m_mem_mode == 3'b000) || (m_mem_mode == 3'b001) ||
                           (m_mem_mode == 3'b010);
        end
    end

    // mode[1:0] encodes the access size: byte, halfword, word.
    always_comb begin
        case (m_mem_mode[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~ex_result[0];
            2'b10:   w_aligned = (ex_result[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_valid  = (w_is_load | w_is_store) & w_mode_legal & w_aligned;
    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle & w_valid;

    // Store lane formatting; loads drive no strobes and zero data on the bus.
    always_comb begin
        w_st_wstrb = 4'b0000;
        w_st_wdata = '0;
        if (w_is_store) begin
            case (m_mem_mode[1:0])
                2'b00: begin
                    w_st_wstrb = 4'b0001 << ex_result[1:0];
                    w_st_wdata = {(XLEN/8){rs2_data[7:0]}};
                end
                2'b01: begin
                    w_st_wstrb = 4'b0011 << {ex_result[1], 1'b0};
                    w_st_wdata = {(XLEN/16){rs2_data[15:0]}};
                end
                default: begin
                    w_st_wstrb = 4'b1111;
                    w_st_wdata = rs2_data;
                end
            endcase
        end
    end

    // Load lane selection uses the offset captured at request time.
    assign w_ld_byte = dmem_rdata[{r_off, 3'b000} +: 8];
    assign w_ld_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (r_mode)
            3'b000:  w_ld_fmt = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_fmt = {{(XLEN-8){1'b0}}, w_ld_byte};
            3'b001:  w_ld_fmt = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_fmt = {{(XLEN-16){1'b0}}, w_ld_half};
            default: w_ld_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_wstrb <= 4'b0000;
            r_mode       <= 3'b000;
            r_off        <= 2'b00;
            r_load_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= w_is_store;
                        r_dmem_addr  <= {ex_result[XLEN-1:2], 2'b00};
                        r_dmem_wdata <= w_st_wdata;
                        r_dmem_wstrb <= w_st_wstrb;
                        r_mode       <= m_mem_mode;
                        r_off        <= ex_result[1:0];
                        r_state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        if (!r_dmem_we) begin
                            r_load_data <= w_ld_fmt;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Pipeline inputs are deliberately not sampled here.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign dmem_wstrb = r_dmem_wstrb;

    // The stall is raised in the accept cycle itself so upstream freezes
    // before the request reaches the bus.
    assign mem_stall = w_accept | (r_state == S_REQ);
    assign misalign  = w_idle & (m_mem_read | m_mem_write) & ~w_valid;

    assign wb_result_out    = ((r_state == S_RESP) && wb_memtoreg) ? r_load_data : ex_result;
    assign rd_index_out     = rd_index;
    assign wb_memtoreg_out  = wb_memtoreg;
    assign wb_reg_write_out = wb_reg_write & ~mem_stall & ~misalign;

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter XLEN SHALL be: XLEN, 32, data/address width.
REQ-002 Parameter RFIDX_WIDTH SHALL be: RFIDX_WIDTH, 5, register-index width.
REQ-003 Port clk SHALL be: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst SHALL be: rst  in  1  reset, synchronous, active-high.
REQ-005 Pipeline-side inputs SHALL be:
- m_mem_read  in  1  load request.
- m_mem_write  in  1  store request.
- m_mem_mode  in  3  funct3 size/sign code.
- ex_result  in  XLEN  byte address, or ALU result for non-memory ops.
- rs2_data  in  XLEN  store data.
- rd_index  in  RFIDX_WIDTH  destination register.
- wb_reg_write  in  1  writeback enable.
- wb_memtoreg  in  1  writeback selects load data.
REQ-006 Bus-side ports SHALL be:
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  XLEN  word address, bits [1:0] = 0.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_wstrb  out  4  byte enables.
- dmem_ack  in  1  one-cycle completion.
- dmem_rdata  in  XLEN  read word, valid with dmem_ack.
REQ-007 Pipeline-side outputs SHALL be:
- mem_stall  out  1  freeze upstream.
- misalign  out  1  access fault.
- wb_result_out  out  XLEN  writeback value.
- rd_index_out  out  RFIDX_WIDTH  destination register.
- wb_reg_write_out  out  1  writeback enable.
- wb_memtoreg_out  out  1  writeback selects load data.

Function
REQ-008 FSM states SHALL be IDLE, REQ, RESP.
REQ-009 In IDLE, a valid access (exactly one of m_mem_read/m_mem_write set, legal mode, aligned address) SHALL latch address, wdata, wstrb, mode and addr[1:0], move to REQ, and assert mem_stall combinationally in that cycle.
REQ-010 Legal load modes SHALL be 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal store modes SHALL be 000 SB, 001 SH, 010 SW.
REQ-011 Alignment SHALL be: halfword requires addr[0]=0; word requires addr[1:0]=0; bytes always aligned.
REQ-012 In IDLE, an illegal mode, a misaligned address, or read and write both set SHALL assert misalign for that cycle, issue no bus request, keep mem_stall=0, force wb_reg_write_out=0, and keep the FSM in IDLE.
REQ-013 In REQ: dmem_req=1, and dmem_we/dmem_addr/dmem_wdata/dmem_wstrb SHALL hold stable until dmem_ack; mem_stall=1.
REQ-014 Latency: the bus may hold dmem_ack low indefinitely (no timeout); minimum request-to-RESP is 1 cycle.
REQ-015 On dmem_ack in REQ: register the formatted load data (loads only), then go to RESP.
REQ-016 In RESP, for exactly one cycle: mem_stall=0, dmem_req=0, and wb_result_out = registered load data when wb_memtoreg=1; then go to IDLE.
REQ-017 RESP SHALL NOT sample the pipeline inputs; the next access is accepted only in IDLE.
REQ-018 Store formatting SHALL be:
- SB: wstrb = 0001 << addr[1:0]; wdata = rs2[7:0] replicated on 4 lanes.
- SH: wstrb = 0011 << (2*addr[1]); wdata = rs2[15:0] replicated on 2 lanes.
- SW: wstrb = 1111; wdata = rs2.
REQ-019 Load formatting SHALL select the byte or halfword by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged.
REQ-020 With no memory op (both request inputs 0): wb_result_out = ex_result and mem_stall = 0.
REQ-021 rd_index_out and wb_memtoreg_out SHALL pass through combinationally; wb_reg_write_out = wb_reg_write AND NOT mem_stall AND NOT misalign.
REQ-022 dmem_ack outside REQ SHALL be ignored.

Reset
REQ-023 A synchronous rst SHALL force IDLE and clear all latched state and the load-data register; after the edge, dmem_req=0, dmem_we=0, dmem_wstrb=0000, dmem_addr=0, dmem_wdata=0.
REQ-024 rst asserted in REQ or RESP SHALL abandon the access; a dmem_ack arriving after reset SHALL be ignored.

Verification
REQ-025 LW, addr 0x100, dmem_ack after 3 cycles with rdata 0xDEADBEEF -> dmem_addr=0x100, mem_stall high 4 cycles, RESP wb_result_out=0xDEADBEEF.
REQ-026 LB, addr 0x103, rdata 0x80000000 -> wb_result_out=0xFFFFFF80; LBU same -> 0x00000080.
REQ-027 SH, addr 0x202, rs2 0x1234ABCD -> dmem_addr=0x200, wstrb=1100, wdata=0xABCDABCD, dmem_we=1.
REQ-028 LW, addr 0x101 -> misalign=1 one cycle, dmem_req never asserted, wb_reg_write_out=0, mem_stall=0.
REQ-029 rst during REQ, then dmem_ack next cycle -> FSM IDLE, dmem_req=0, no RESP cycle, wb_reg_write_out gated only by inputs.
REQ-030 Back-to-back SW 0x0 then LW 0x4, each acked in 1 cycle -> two distinct bus requests, IDLE between them, no duplicate request.
